// File: rtl/cpu_pipe_pkg.sv
// Shared types and constants for the integer pipeline front end.
package cpu_pipe_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [XLEN-1:0]  NOP_INSTR       = 32'h0000_0000;
  localparam logic [OPC_W-1:0] HALT_OPCODE_DEF = 6'b111111;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_SEQ   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_sel_e;

  // Per-cycle register update commands from the fetch FSM to the datapath.
  typedef struct packed {
    pc_sel_e   pc_sel;
    ifid_sel_e ifid_sel;
    logic      cnt_inc;
    logic      halt_set;
    logic      halt_clr;
  } fetch_ctrl_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [XLEN-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_fsm.sv
// Fetch sequencing: BOOT/RUN/HALT state plus load/flush/hold decode for the
// PC, IF/ID and counter registers.
module fetch_fsm
  import cpu_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic        halt_hit,
  output fetch_ctrl_t ctrl_c
);

  fetch_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  // Redirect outranks stall and halt detection in every state.
  always_comb begin
    state_d = state_q;
    ctrl_c  = '{pc_sel: PC_HOLD, ifid_sel: IFID_HOLD,
                cnt_inc: 1'b0, halt_set: 1'b0, halt_clr: 1'b0};
    if (redirect_valid) begin
      ctrl_c.pc_sel   = PC_REDIR;
      ctrl_c.ifid_sel = IFID_BUBBLE;
      ctrl_c.halt_clr = 1'b1;
      state_d         = ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (!stall) begin
            if (halt_hit) begin
              ctrl_c.ifid_sel = IFID_BUBBLE;
              ctrl_c.halt_set = 1'b1;
              state_d         = ST_HALT;
            end else begin
              ctrl_c.pc_sel   = PC_SEQ;
              ctrl_c.ifid_sel = IFID_LOAD;
              ctrl_c.cnt_inc  = 1'b1;
            end
          end
        end
        ST_HALT: ctrl_c.ifid_sel = IFID_BUBBLE;
        default: state_d = ST_BOOT;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// Pipeline stage 1: program counter, instruction-memory address and the
// IF/ID register with stall, redirect/flush, halt and fetch counting.
module instr_fetch_stage
  import cpu_pipe_pkg::*;
#(
  parameter logic [31:0]       RESET_PC    = 32'h0000_0000,
  parameter logic [OPC_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEF,
  parameter int unsigned       COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic [31:0]        pc_plus4,
  input  logic [31:0]        instr,
  output logic [31:0]        instr_addr,
  output logic [31:0]        if_instr,
  output logic [31:0]        if_pc4,
  output logic               if_valid,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count
);

  localparam logic [31:0] ALIGN_MASK = ~32'h0000_0003;
  localparam logic [31:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

  logic [31:0]        pc_q, pc_d;
  logic [31:0]        if_instr_q, if_instr_d;
  logic [31:0]        if_pc4_q, if_pc4_d;
  logic               if_valid_q, if_valid_d;
  logic               halted_q, halted_d;
  logic [COUNT_W-1:0] fetch_count_q, fetch_count_d;
  fetch_ctrl_t        ctrl_c;
  logic               halt_hit_c;

  assign halt_hit_c = (opcode_of(instr) == HALT_OPCODE);

  fetch_fsm u_fetch_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .halt_hit       (halt_hit_c),
    .ctrl_c         (ctrl_c)
  );

  always_comb begin
    pc_d          = pc_q;
    if_instr_d    = if_instr_q;
    if_pc4_d      = if_pc4_q;
    if_valid_d    = if_valid_q;
    halted_d      = halted_q;
    fetch_count_d = fetch_count_q;

    case (ctrl_c.pc_sel)
      PC_SEQ:   pc_d = pc_plus4 & ALIGN_MASK;
      PC_REDIR: pc_d = redirect_pc & ALIGN_MASK;
      default:  pc_d = pc_q;
    endcase

    case (ctrl_c.ifid_sel)
      IFID_LOAD: begin
        if_instr_d = instr;
        if_pc4_d   = pc_plus4;
        if_valid_d = 1'b1;
      end
      IFID_BUBBLE: begin
        if_instr_d = NOP_INSTR;
        if_valid_d = 1'b0;
      end
      default: ;
    endcase

    if (ctrl_c.halt_clr)      halted_d = 1'b0;
    else if (ctrl_c.halt_set) halted_d = 1'b1;

    // Counter sticks at all-ones rather than wrapping.
    if (ctrl_c.cnt_inc && (fetch_count_q != {COUNT_W{1'b1}}))
      fetch_count_d = fetch_count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC_A;
      if_instr_q    <= NOP_INSTR;
      if_pc4_q      <= 32'h0;
      if_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_instr_q    <= if_instr_d;
      if_pc4_q      <= if_pc4_d;
      if_valid_q    <= if_valid_d;
      halted_q      <= halted_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign instr_addr  = pc_q;
  assign if_instr    = if_instr_q;
  assign if_pc4      = if_pc4_q;
  assign if_valid    = if_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage with a behavioural fetch model
// and a small instruction memory driven from instr_addr.
module tb_instr_fetch_stage;

  localparam int unsigned TB_COUNT_W = 3;
  localparam int unsigned CNT_MAX    = (1 << TB_COUNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  stall;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic [31:0]           pc_plus4;
  logic [31:0]           instr;
  logic [31:0]           instr_addr;
  logic [31:0]           if_instr;
  logic [31:0]           if_pc4;
  logic                  if_valid;
  logic                  halted;
  logic [TB_COUNT_W-1:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];
  int          mem_gen = 0;

  // Reference model state
  logic [31:0] m_pc, m_if_instr, m_if_pc4;
  bit          m_if_valid, m_halted, m_booting;
  int unsigned m_count;

  instr_fetch_stage #(
    .RESET_PC    (32'h0000_0000),
    .HALT_OPCODE (6'b111111),
    .COUNT_W     (TB_COUNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc_plus4       (pc_plus4),
    .instr          (instr),
    .instr_addr     (instr_addr),
    .if_instr       (if_instr),
    .if_pc4         (if_pc4),
    .if_valid       (if_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_rd(input logic [31:0] a);
    if (a < 32'h400) return mem[a[9:2]];
    return {6'b001000, a[25:0]};
  endfunction

  always @(instr_addr or mem_gen) instr = imem_rd(instr_addr);
  assign pc_plus4 = instr_addr + 32'd4;

  function automatic void model_reset();
    m_pc = 32'h0; m_if_instr = 32'h0; m_if_pc4 = 32'h0;
    m_if_valid = 0; m_halted = 0; m_booting = 1; m_count = 0;
  endfunction

  // Fetch rules: redirect wins; first cycle after reset idles; halted holds;
  // otherwise a non-stalled fetch either delivers the word or halts on it.
  function automatic void model_step(input bit st, input bit rd, input logic [31:0] rpc);
    logic [31:0] w;
    if (rd) begin
      m_pc = {rpc[31:2], 2'b00};
      m_if_instr = 32'h0; m_if_valid = 0; m_halted = 0; m_booting = 0;
    end else if (m_booting) begin
      m_booting = 0;
    end else if (!m_halted && !st) begin
      w = imem_rd(m_pc);
      if (w[31:26] == 6'h3F) begin
        m_if_instr = 32'h0; m_if_valid = 0; m_halted = 1;
      end else begin
        m_if_instr = w; m_if_pc4 = m_pc + 32'd4; m_if_valid = 1;
        m_pc = m_pc + 32'd4;
        if (m_count < CNT_MAX) m_count = m_count + 1;
      end
    end
  endfunction

  task automatic cycle(input bit st, input bit rd, input logic [31:0] rpc);
    stall = st; redirect_valid = rd; redirect_pc = rpc;
    model_step(st, rd, rpc);
    @(posedge clk); #1;
    stall = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (instr_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", instr_addr, 32'h0); end
    n_checks++; if ({if_valid, halted, fetch_count} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got v=%b h=%b c=%0d want 0", if_valid, halted, fetch_count); end
    n_checks++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", if_instr); end
    rst_n = 1'b1; model_reset();
    cycle(0, 1, 32'h40);
    cycle(0, 0, 32'h0);
    n_checks++; if (instr_addr !== 32'h44) begin n_fail++; $display("FAIL run_pc: got %h want %h", instr_addr, 32'h44); end
    // Asynchronous reset in mid-cycle
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (instr_addr !== 32'h0) begin n_fail++; $display("FAIL async_reset_pc: got %h want 0", instr_addr); end
    n_checks++; if (if_valid !== 1'b0 || fetch_count !== '0) begin n_fail++; $display("FAIL async_reset_state: got v=%b c=%0d want 0/0", if_valid, fetch_count); end
    @(posedge clk); #1 rst_n = 1'b1; model_reset();
    cycle(0, 0, 32'h0);
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL boot_bubble: got %b want 0", if_valid); end
    cycle(0, 0, 32'h0);
    n_checks++; if (if_valid !== 1'b1 || if_instr !== 32'h2001_0005) begin n_fail++; $display("FAIL first_fetch: got v=%b %h want 1 20010005", if_valid, if_instr); end
  endtask

  task automatic test_sequential();
    do_reset();
    cycle(0, 0, 32'h0);
    cycle(0, 0, 32'h0);
    n_checks++; if (if_instr !== 32'h2001_0005 || if_pc4 !== 32'h4) begin n_fail++; $display("FAIL seq0: got %h/%h want 20010005/4", if_instr, if_pc4); end
    cycle(0, 0, 32'h0);
    n_checks++; if (if_instr !== 32'h2002_0003 || if_pc4 !== 32'h8) begin n_fail++; $display("FAIL seq1: got %h/%h want 20020003/8", if_instr, if_pc4); end
    n_checks++; if (fetch_count !== 3'd2) begin n_fail++; $display("FAIL seq_count: got %0d want 2", fetch_count); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 32'h0);
      n_checks++; if (instr_addr !== 32'h8 || if_instr !== 32'h2002_0003 || if_valid !== 1'b1 || fetch_count !== 3'd2) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got pc=%h i=%h v=%b c=%0d want 8/20020003/1/2", i, instr_addr, if_instr, if_valid, fetch_count);
      end
    end
    cycle(0, 0, 32'h0);
    n_checks++; if (if_instr !== 32'h2003_000A || if_pc4 !== 32'hC || fetch_count !== 3'd3) begin n_fail++; $display("FAIL stall_resume: got %h/%h c=%0d want 2003000a/c/3", if_instr, if_pc4, fetch_count); end
  endtask

  task automatic test_halt();
    cycle(0, 0, 32'h0);
    n_checks++; if (halted !== 1'b1 || if_valid !== 1'b0 || if_instr !== 32'h0 || instr_addr !== 32'hC) begin
      n_fail++; $display("FAIL halt_enter: got h=%b v=%b i=%h pc=%h want 1/0/0/c", halted, if_valid, if_instr, instr_addr);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(i[0], 0, 32'h0);
      n_checks++; if (halted !== 1'b1 || instr_addr !== 32'hC || if_valid !== 1'b0 || fetch_count !== 3'd3) begin
        n_fail++; $display("FAIL halt_hold[%0d]: got h=%b pc=%h v=%b c=%0d want 1/c/0/3", i, halted, instr_addr, if_valid, fetch_count);
      end
    end
    cycle(0, 1, 32'h0);
    n_checks++; if (halted !== 1'b0 || instr_addr !== 32'h0 || if_valid !== 1'b0) begin n_fail++; $display("FAIL halt_exit: got h=%b pc=%h v=%b want 0/0/0", halted, instr_addr, if_valid); end
    cycle(0, 0, 32'h0);
    n_checks++; if (if_instr !== 32'h2001_0005 || if_valid !== 1'b1 || fetch_count !== 3'd4) begin n_fail++; $display("FAIL halt_resume: got %h v=%b c=%0d want 20010005/1/4", if_instr, if_valid, fetch_count); end
  endtask

  task automatic test_redirect_stall();
    cycle(1, 1, 32'h103);
    n_checks++; if (instr_addr !== 32'h100 || if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stall: got pc=%h v=%b want 100/0", instr_addr, if_valid); end
    cycle(0, 0, 32'h0);
    n_checks++; if (if_instr !== 32'h2004_ABCD || if_pc4 !== 32'h104 || if_valid !== 1'b1 || fetch_count !== 3'd5) begin
      n_fail++; $display("FAIL redir_target: got %h/%h v=%b c=%0d want 2004abcd/104/1/5", if_instr, if_pc4, if_valid, fetch_count);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    cycle(0, 0, 32'h0);
    cycle(0, 1, 32'h200);
    for (int k = 1; k <= 10; k++) begin
      cycle(0, 0, 32'h0);
      n_checks++; if (fetch_count !== 3'((k > 7) ? 7 : k)) begin n_fail++; $display("FAIL sat[%0d]: got %0d want %0d", k, fetch_count, (k > 7) ? 7 : k); end
    end
  endtask

  task automatic test_wrap();
    cycle(0, 1, 32'hFFFF_FFF8);
    cycle(0, 0, 32'h0);
    n_checks++; if (if_pc4 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap0: got %h want fffffffc", if_pc4); end
    cycle(0, 0, 32'h0);
    n_checks++; if (if_pc4 !== 32'h0 || instr_addr !== 32'h0 || fetch_count !== 3'd7) begin n_fail++; $display("FAIL wrap1: got pc4=%h pc=%h c=%0d want 0/0/7", if_pc4, instr_addr, fetch_count); end
  endtask

  task automatic test_random();
    bit          st, rd;
    logic [31:0] rpc;
    for (int i = 128; i < 256; i++)
      mem[i] = ($urandom_range(0, 11) == 0) ? {6'b111111, 26'($urandom)} : {6'b000100 + 6'($urandom_range(0, 40)), 26'($urandom)};
    mem_gen++;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rd  = (n == 1) || ($urandom_range(0, 15) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rpc = 32'h200 + 32'($urandom_range(0, 32'h1FF));
      cycle(st, rd, rpc);
      n_checks++;
      if (instr_addr !== m_pc || if_instr !== m_if_instr || if_valid !== m_if_valid || halted !== m_halted ||
          fetch_count !== TB_COUNT_W'(m_count) || (m_if_valid && if_pc4 !== m_if_pc4)) begin
        n_fail++;
        $display("FAIL rand[%0d]: got pc=%h i=%h pc4=%h v=%b h=%b c=%0d want pc=%h i=%h pc4=%h v=%b h=%b c=%0d",
                 n, instr_addr, if_instr, if_pc4, if_valid, halted, fetch_count,
                 m_pc, m_if_instr, m_if_pc4, m_if_valid, m_halted, m_count);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {6'b001000, 10'(i), 16'h0001};
    mem[0]  = 32'h2001_0005;
    mem[1]  = 32'h2002_0003;
    mem[2]  = 32'h2003_000A;
    mem[3]  = 32'hFC00_0000;
    mem[64] = 32'h2004_ABCD;
    mem_gen++;
    test_reset();
    test_sequential();
    test_stall();
    test_halt();
    test_redirect_stall();
    test_saturation();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
